// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone classic arbiter: round-robin grant held for the whole cyc, watchdog turns a hung slave into err.
// Grant is registered (one cycle from request); once granted, the datapath and slave responses pass through combinationally.
module wb_arbiter_2 #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,

  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic [15:0] LP_WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic [1:0]  r_grant;
  logic [15:0] r_wdog;

  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_stb;
  logic w_slv_rsp;
  logic w_timeout_hit;

  assign w_gnt0        = (r_state == S_GNT0);
  assign w_gnt1        = (r_state == S_GNT1);
  assign w_gnt_stb     = (w_gnt0 & wbm0_stb_i) | (w_gnt1 & wbm1_stb_i);
  assign w_slv_rsp     = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A real slave response in the last allowed cycle beats the forced err.
  assign w_timeout_hit = w_gnt_stb & ~w_slv_rsp & (r_wdog == LP_WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wbm0_cyc_i && (!wbm1_cyc_i || r_last_grant)) begin
            r_state <= S_GNT0;
            r_grant <= 2'b01;
          end else if (wbm1_cyc_i) begin
            r_state <= S_GNT1;
            r_grant <= 2'b10;
          end
        end
        S_GNT0: begin
          if (!wbm0_cyc_i) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b0;
          end
        end
        S_GNT1: begin
          if (!wbm1_cyc_i) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_gnt_stb || w_slv_rsp || w_timeout_hit) begin
      r_wdog <= 16'd0;
    end else begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_sel_o  = '0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    if (w_gnt0) begin
      wbs_adr_o  = wbm0_adr_i;
      wbs_dat_o  = wbm0_dat_i;
      wbs_we_o   = wbm0_we_i;
      wbs_sel_o  = wbm0_sel_i;
      wbs_cyc_o  = wbm0_cyc_i;
      wbs_stb_o  = wbm0_stb_i & ~w_timeout_hit;
      wbm0_ack_o = wbs_ack_i;
      wbm0_err_o = wbs_err_i | w_timeout_hit;
      wbm0_rty_o = wbs_rty_i;
    end else if (w_gnt1) begin
      wbs_adr_o  = wbm1_adr_i;
      wbs_dat_o  = wbm1_dat_i;
      wbs_we_o   = wbm1_we_i;
      wbs_sel_o  = wbm1_sel_i;
      wbs_cyc_o  = wbm1_cyc_i;
      wbs_stb_o  = wbm1_stb_i & ~w_timeout_hit;
      wbm1_ack_o = wbs_ack_i;
      wbm1_err_o = wbs_err_i | w_timeout_hit;
      wbm1_rty_o = wbs_rty_i;
    end
  end

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign grant      = r_grant;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_cyc_granted:  assert property (@(posedge clk) disable iff (rst) wbs_cyc_o |-> (grant != 2'b00));
  a_no_handoff01: assert property (@(posedge clk) disable iff (rst) (grant == 2'b01) |=> (grant != 2'b10));
  a_no_handoff10: assert property (@(posedge clk) disable iff (rst) (grant == 2'b10) |=> (grant != 2'b01));
  a_tmo_single:   assert property (@(posedge clk) disable iff (rst)
                    ((TIMEOUT > 1) && w_timeout_hit) |=> !w_timeout_hit);

endmodule
